// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard using
// the request-to-send sequence (inhibit clock, pull data low as the start bit,
// release clock) and then follows the device-generated clock to shift out the
// data bits, odd parity and stop bit. It then checks the device ACK bit.
// The top level drives the pins open-drain: PS2_x = oe ? 1'b0 : 1'bz.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-low
//   i_cmd_data     byte to send, sampled on accept
//   i_cmd_valid    request; accepted when i_cmd_valid & o_cmd_ready
//   o_cmd_ready    high only while idle (registered)
//   i_ps2_clk      raw PS2_CLK pin level (asynchronous)
//   i_ps2_dat      raw PS2_DAT pin level (asynchronous)
//   o_ps2_clk_oe   1 = pull PS2_CLK low
//   o_ps2_dat_oe   1 = pull PS2_DAT low
//   o_busy         high in every state except idle; receive path ignores lines
//   o_done         1-cycle pulse: byte sent, ACK received, lines idle again
//   o_error        1-cycle pulse: NACK or timeout
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 100,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_cmd_data,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_dat_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  localparam int PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX) + 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t            r_state;
  logic              r_clk_meta, r_clk_sync, r_clk_prev;
  logic              r_dat_meta, r_dat_sync;
  logic [7:0]        r_shift;
  logic              r_parity;
  logic [3:0]        r_edges;
  logic [PH_W-1:0]   r_phase;
  logic [TO_W-1:0]   r_tmo;
  logic              r_clk_oe, r_dat_oe, r_busy, r_done, r_error, r_ready;
  logic              w_fall;
  logic              w_timeout;

  // Synchronizers start at the idle (high) line level so that leaving reset
  // never produces a spurious falling-edge strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= i_ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= i_ps2_dat;
      r_dat_sync <= r_dat_meta;
    end
  end

  assign w_fall    = r_clk_prev & ~r_clk_sync;
  assign w_timeout = (r_tmo == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_ready  <= 1'b0;
      r_shift  <= 8'h00;
      r_parity <= 1'b0;
      r_edges  <= 4'd0;
      r_phase  <= '0;
      r_tmo    <= '0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Ready is registered, so it rises one cycle after any return to idle.
          if (i_cmd_valid && r_ready) begin
            r_shift  <= i_cmd_data;
            r_parity <= ~^i_cmd_data;
            r_edges  <= 4'd0;
            r_phase  <= '0;
            r_clk_oe <= 1'b1;
            r_busy   <= 1'b1;
            r_ready  <= 1'b0;
            r_state  <= S_INHIBIT;
          end else begin
            r_ready  <= 1'b1;
          end
        end
        S_INHIBIT: begin
          if (r_phase == PH_W'(INHIBIT_CYCLES - 1)) begin
            r_phase  <= '0;
            r_dat_oe <= 1'b1;            // start bit
            r_state  <= S_REQ;
          end else begin
            r_phase  <= r_phase + 1'b1;
          end
        end
        S_REQ: begin
          if (r_phase == PH_W'(REQ_CYCLES - 1)) begin
            r_clk_oe <= 1'b0;            // hand the clock to the device
            r_tmo    <= '0;
            r_state  <= S_SHIFT;
          end else begin
            r_phase  <= r_phase + 1'b1;
          end
        end
        S_SHIFT, S_ACK, S_WAIT_IDLE: begin
          r_tmo <= r_tmo + 1'b1;
          if (w_timeout) begin
            // Timeout takes priority over a coincident clock fall.
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_error  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_state == S_SHIFT) begin
            // Data changes only after a fall; the device samples on the rise.
            if (w_fall) begin
              r_edges <= r_edges + 1'b1;
              if (r_edges < 4'd8) begin
                r_dat_oe <= ~r_shift[0];
                r_shift  <= {1'b0, r_shift[7:1]};
              end else if (r_edges == 4'd8) begin
                r_dat_oe <= ~r_parity;
              end else begin
                r_dat_oe <= 1'b0;        // stop bit: release the line
                r_state  <= S_ACK;
              end
            end
          end else if (r_state == S_ACK) begin
            if (w_fall) begin
              if (r_dat_sync) begin
                r_error <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_state <= S_WAIT_IDLE;
              end
            end
          end else begin
            if (r_clk_sync && r_dat_sync) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready  = r_ready;
  assign o_ps2_clk_oe = r_clk_oe;
  assign o_ps2_dat_oe = r_dat_oe;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Drives ps2_host_tx against a behavioural PS/2 device that generates the
// clock, captures the frame on rising edges and answers with ACK or NACK (or
// stays silent). Expected outcomes go into a scoreboard queue when a command
// is issued; a monitor pops and compares whenever done/error pulses.
// Cycle counts are shortened through the parameters to keep runs quick.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int REQ = 8;
  localparam int TMO = 3000;

  localparam int M_ACK    = 0;
  localparam int M_NACK   = 1;
  localparam int M_SILENT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready, clk_oe, dat_oe, busy, done, error;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       line_clk, line_dat;

  // Open-drain wired-AND of host and device on each line.
  assign line_clk = ~(clk_oe | dev_clk_low);
  assign line_dat = ~(dat_oe | dev_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (REQ),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_cmd_data  (cmd_data),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_ps2_clk   (line_clk),
    .i_ps2_dat   (line_dat),
    .o_ps2_clk_oe(clk_oe),
    .o_ps2_dat_oe(dat_oe),
    .o_busy      (busy),
    .o_done      (done),
    .o_error     (error)
  );

  typedef struct {
    logic [7:0] data;
    int         mode;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [10:1] dev_bits = '0;
  logic        pulse_prev = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference frame as the device should see it: 8 data bits LSB first, then
  // a parity bit making the total count of ones odd, then a stop bit of 1.
  function automatic logic [10:1] expected_frame(input logic [7:0] d);
    logic [10:1] f;
    int ones;
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      f[k + 1] = d[k];
      if (d[k]) ones++;
    end
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  // Monitor: compares each done/error pulse with the oldest expected outcome.
  always @(negedge clk) begin
    if (reset) begin
      if (pulse_prev) begin
        check("pulse_one_cycle", 32'({done, error}), 32'd0);
        check("ready_after_pulse", 32'(cmd_ready), 32'd1);
      end
      pulse_prev = done | error;
      if (done | error) begin
        check("done_error_exclusive", 32'(done & error), 32'd0);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got done=%0b error=%0b expected none", done, error);
        end else begin
          e = sb_q.pop_front();
          check("outcome_done", 32'(done), 32'(e.mode == M_ACK));
          check("outcome_error", 32'(error), 32'(e.mode != M_ACK));
          if (e.mode != M_SILENT)
            check("frame_bits", 32'(dev_bits), 32'(expected_frame(e.data)));
        end
      end
    end else begin
      pulse_prev = 1'b0;
    end
  end

  // Issue one command and play the device side. abort_after > 0 stops the
  // device after that many clock falls (clock left low) and returns early.
  task automatic send(input logic [7:0] d, input int mode, input int abort_after);
    int n, h, bad;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", 32'(cmd_ready), 32'd1);
    dev_bits = '0;
    cmd_data = d;
    cmd_valid = 1'b1;
    sb_q.push_back('{d, mode});
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("send 0x%02h mode %0d", d, mode);

    bad = 0;
    n = 0;
    while (clk_oe && !dat_oe && n < INH + 10) begin
      if (cmd_ready || !busy) bad++;
      n++;
      @(negedge clk);
    end
    check("inhibit_len", 32'(n), 32'(INH));
    n = 0;
    while (clk_oe && dat_oe && n < REQ + 10) begin
      if (cmd_ready || !busy) bad++;
      n++;
      @(negedge clk);
    end
    check("req_len", 32'(n), 32'(REQ));
    check("clk_released_start_held", 32'({clk_oe, dat_oe}), 32'b01);
    check("ready_low_busy_high", 32'(bad), 32'd0);

    if (mode == M_SILENT) begin
      n = 0;
      while (!error && n < TMO + 10) begin
        n++;
        @(negedge clk);
      end
      check("timeout_len", 32'(n), 32'(TMO));
      check("timeout_release", 32'({clk_oe, dat_oe}), 32'd0);
    end else begin
      h = $urandom_range(12, 25);
      repeat (h) @(negedge clk);
      check("start_before_fall", 32'({clk_oe, dat_oe}), 32'b01);
      for (int i = 1; i <= 11; i++) begin
        dev_clk_low = 1'b1;
        if (i == abort_after) begin
          repeat (h / 2) @(negedge clk);
          return;
        end
        repeat (h) @(negedge clk);
        dev_clk_low = 1'b0;
        if (i <= 10) dev_bits[i] = line_dat;
        if (i == 10 && mode == M_ACK) dev_dat_low = 1'b1;
        if (i == 11) dev_dat_low = 1'b0;
        repeat (h) @(negedge clk);
      end
    end

    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("outcome_seen", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    check("idle_after", 32'({clk_oe, dat_oe, busy, cmd_ready}), 32'b0001);
  endtask

  initial begin
    int m;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({clk_oe, dat_oe, busy, done, error, cmd_ready}), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'({cmd_ready, busy}), 32'b10);

    send(8'hED, M_ACK, 0);
    send(8'h07, M_ACK, 0);
    send(8'h00, M_ACK, 0);
    send(8'h55, M_ACK, 0);
    send(8'($urandom), M_NACK, 0);
    send(8'($urandom), M_SILENT, 0);
    send(8'hFF, M_ACK, 0);

    // Reset in the middle of a frame, after the fifth clock fall.
    send(8'hED, M_ACK, 5);
    reset = 1'b0;
    @(negedge clk);
    check("midframe_reset", 32'({clk_oe, dat_oe, busy, done, error, cmd_ready}), 32'd0);
    sb_q.delete();
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_midframe_reset", 32'(cmd_ready), 32'd1);
    send(8'hF4, M_ACK, 0);

    for (int r = 0; r < 5; r++) begin
      m = ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK;
      send(8'($urandom), m, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
